// File: rtl/multiinputconditioner_pkg.sv
// Shared constants for the multi-channel input conditioner.
package multiinputconditioner_pkg;

  localparam int unsigned CHANNELS      = 4;
  localparam int unsigned SYNCSTAGES    = 2;
  localparam int unsigned COUNTERWIDTH  = 3;

  // Legal synchroniser depth range, checked at elaboration.
  localparam int unsigned MINSYNCSTAGES = 2;
  localparam int unsigned MAXSYNCSTAGES = 4;

endpackage : multiinputconditioner_pkg

// File: rtl/multiinputconditioner_if.sv
// Bus bundle for the conditioner: raw inputs, enables and threshold in,
// debounced levels and edge pulses out.
//   master: drives noisysignal/enable/waittime, observes results
//   slave : the conditioner itself
interface multiinputconditioner_if
  import multiinputconditioner_pkg::*;
#(
  parameter int unsigned channels     = CHANNELS,
  parameter int unsigned counterwidth = COUNTERWIDTH
);

  logic [channels-1:0]     noisysignal;
  logic [channels-1:0]     enable;
  logic [counterwidth-1:0] waittime;
  logic [channels-1:0]     conditioned;
  logic [channels-1:0]     positiveedge;
  logic [channels-1:0]     negativeedge;
  logic                    anyedge;

  modport master (
    output noisysignal, enable, waittime,
    input  conditioned, positiveedge, negativeedge, anyedge
  );

  modport slave (
    input  noisysignal, enable, waittime,
    output conditioned, positiveedge, negativeedge, anyedge
  );

endinterface : multiinputconditioner_if

// File: rtl/multiinputconditioner_conditionerchannel.sv
// One input line: synchroniser chain, debounce counter and registered
// edge pulses.
//   clk, reset   : clock, synchronous active-high reset
//   noisy        : raw asynchronous input
//   enable       : debounce enable (synchroniser runs regardless)
//   waittime     : debounce threshold
//   conditioned  : debounced level
//   positiveedge : 1-cycle pulse on conditioned 0->1
//   negativeedge : 1-cycle pulse on conditioned 1->0
module conditionerchannel
  import multiinputconditioner_pkg::*;
#(
  parameter int unsigned syncstages   = SYNCSTAGES,
  parameter int unsigned counterwidth = COUNTERWIDTH,
  parameter logic        resetbit     = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    noisy,
  input  logic                    enable,
  input  logic [counterwidth-1:0] waittime,
  output logic                    conditioned,
  output logic                    positiveedge,
  output logic                    negativeedge
);

  if (syncstages < MINSYNCSTAGES || syncstages > MAXSYNCSTAGES) begin : g_bad_syncstages
    $error("conditionerchannel: syncstages out of legal range");
  end

  logic [syncstages-1:0]   stages;
  logic [counterwidth-1:0] counter;
  logic                    synced;

  assign synced = stages[syncstages-1];

  // Synchroniser, debounce counter and edge pulses; the >= compare fires
  // before the counter can wrap, and a lowered waittime applies at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      stages       <= {syncstages{resetbit}};
      conditioned  <= resetbit;
      counter      <= '0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
    end else begin
      stages       <= {stages[syncstages-2:0], noisy};
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
      if (!enable || (synced == conditioned)) begin
        counter <= '0;
      end else if (counter >= waittime) begin
        counter      <= '0;
        conditioned  <= synced;
        positiveedge <= synced;
        negativeedge <= ~synced;
      end else begin
        counter <= counter + counterwidth'(1);
      end
    end
  end

endmodule : conditionerchannel

// File: rtl/multiinputconditioner.sv
// Multi-channel input conditioner: independent synchronise/debounce per
// line with a shared runtime debounce threshold.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of multiinputconditioner_if
//                (noisysignal, enable, waittime in;
//                 conditioned, positiveedge, negativeedge, anyedge out)
module multiinputconditioner
  import multiinputconditioner_pkg::*;
#(
  parameter int unsigned         channels     = CHANNELS,
  parameter int unsigned         syncstages   = SYNCSTAGES,
  parameter int unsigned         counterwidth = COUNTERWIDTH,
  parameter logic [channels-1:0] resetvalue   = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  multiinputconditioner_if.slave   bus
);

  logic [channels-1:0] cond;
  logic [channels-1:0] pos;
  logic [channels-1:0] neg;

  // One conditioner per line, each with its own reset level.
  for (genvar i = 0; i < channels; i++) begin : g_chan
    conditionerchannel #(
      .syncstages   (syncstages),
      .counterwidth (counterwidth),
      .resetbit     (resetvalue[i])
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .noisy        (bus.noisysignal[i]),
      .enable       (bus.enable[i]),
      .waittime     (bus.waittime),
      .conditioned  (cond[i]),
      .positiveedge (pos[i]),
      .negativeedge (neg[i])
    );
  end

  assign bus.conditioned  = cond;
  assign bus.positiveedge = pos;
  assign bus.negativeedge = neg;

  // Combinational OR of the registered pulses, same cycle as the pulses.
  assign bus.anyedge = |{pos, neg};

endmodule : multiinputconditioner

// File: tb/tb_multiinputconditioner.sv
module tb_multiinputconditioner;

  localparam logic [3:0] RV = 4'b0101;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  pos;
    logic [3:0]  neg;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  multiinputconditioner_if #(.channels(4), .counterwidth(3)) bif ();

  multiinputconditioner #(
    .channels     (4),
    .syncstages   (2),
    .counterwidth (3),
    .resetvalue   (RV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int unsigned cyc = 0;
  logic [3:0]  exp_cond = RV;
  logic [3:0]  exp_pos = '0;
  logic [3:0]  exp_neg = '0;
  int          errors = 0;
  int          checks = 0;

  // Expect a pulse rel edges from now (rel=0 is the next edge).
  task automatic expect_at(input int unsigned rel, input logic [3:0] p, input logic [3:0] n);
    exp_t e;
    e.cyc = cyc + rel;
    e.pos = p;
    e.neg = n;
    sb.push_back(e);
  endtask

  // Advance one edge and derive expected outputs from the scoreboard.
  task automatic tick();
    logic rs;
    exp_t e;
    rs = reset;
    @(posedge clk);
    #1;
    exp_pos = '0;
    exp_neg = '0;
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      if (!rs) begin
        exp_pos |= e.pos;
        exp_neg |= e.neg;
      end
    end
    exp_cond = rs ? RV : ((exp_cond | exp_pos) & ~exp_neg);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bif.noisysignal = 4'b0000;
    bif.enable = 4'b1111;
    bif.waittime = 3'd3;
    repeat (2) begin
      tick();
      checks++;
      if ({bif.conditioned, bif.positiveedge, bif.negativeedge, bif.anyedge} !==
          {exp_cond, exp_pos, exp_neg, |{exp_pos, exp_neg}}) begin
        errors++;
        $display("FAIL reset cyc=%0d got c=%b p=%b n=%b a=%b want c=%b p=%b n=%b a=%b", cyc,
                 bif.conditioned, bif.positiveedge, bif.negativeedge, bif.anyedge,
                 exp_cond, exp_pos, exp_neg, |{exp_pos, exp_neg});
      end
    end
    reset = 1'b0;
    expect_at(5, 4'b0000, 4'b0101);
    repeat (8) begin
      tick();
      checks++;
      if ({bif.conditioned, bif.positiveedge, bif.negativeedge, bif.anyedge} !==
          {exp_cond, exp_pos, exp_neg, |{exp_pos, exp_neg}}) begin
        errors++;
        $display("FAIL reset_fall cyc=%0d got c=%b p=%b n=%b a=%b want c=%b p=%b n=%b a=%b", cyc,
                 bif.conditioned, bif.positiveedge, bif.negativeedge, bif.anyedge,
                 exp_cond, exp_pos, exp_neg, |{exp_pos, exp_neg});
      end
    end
  endtask

  task automatic test_rise();
    bif.noisysignal = 4'b0010;
    expect_at(5, 4'b0010, 4'b0000);
    repeat (8) begin
      tick();
      checks++;
      if ({bif.conditioned, bif.positiveedge, bif.negativeedge, bif.anyedge} !==
          {exp_cond, exp_pos, exp_neg, |{exp_pos, exp_neg}}) begin
        errors++;
        $display("FAIL rise cyc=%0d got c=%b p=%b n=%b a=%b want c=%b p=%b n=%b a=%b", cyc,
                 bif.conditioned, bif.positiveedge, bif.negativeedge, bif.anyedge,
                 exp_cond, exp_pos, exp_neg, |{exp_pos, exp_neg});
      end
    end
  endtask

  task automatic test_glitch();
    // 3-cycle glitch is rejected, then a stable high and low are accepted.
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: bif.noisysignal[3] = 1'b1;
        1: bif.noisysignal[3] = 1'b0;
        2: begin bif.noisysignal[3] = 1'b1; expect_at(5, 4'b1000, 4'b0000); end
        default: begin bif.noisysignal[3] = 1'b0; expect_at(5, 4'b0000, 4'b1000); end
      endcase
      repeat ((ph == 0) ? 3 : 8) begin
        tick();
        checks++;
        if ({bif.conditioned, bif.positiveedge, bif.negativeedge, bif.anyedge} !==
            {exp_cond, exp_pos, exp_neg, |{exp_pos, exp_neg}}) begin
          errors++;
          $display("FAIL glitch ph=%0d cyc=%0d got c=%b p=%b n=%b a=%b want c=%b p=%b n=%b a=%b",
                   ph, cyc, bif.conditioned, bif.positiveedge, bif.negativeedge, bif.anyedge,
                   exp_cond, exp_pos, exp_neg, |{exp_pos, exp_neg});
        end
      end
    end
  endtask

  task automatic test_waittime();
    // wt=0 rise, wt=7 fall, wt 7->2 after count 5.
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin bif.waittime = 3'd0; bif.noisysignal[0] = 1'b1; expect_at(2, 4'b0001, 4'b0000); end
        1: begin bif.waittime = 3'd7; bif.noisysignal[0] = 1'b0; expect_at(9, 4'b0000, 4'b0001); end
        2: begin bif.noisysignal[0] = 1'b1; expect_at(7, 4'b0001, 4'b0000); end
        default: bif.waittime = 3'd2;
      endcase
      repeat ((ph == 0) ? 5 : (ph == 1) ? 12 : (ph == 2) ? 7 : 4) begin
        tick();
        checks++;
        if ({bif.conditioned, bif.positiveedge, bif.negativeedge, bif.anyedge} !==
            {exp_cond, exp_pos, exp_neg, |{exp_pos, exp_neg}}) begin
          errors++;
          $display("FAIL waittime ph=%0d cyc=%0d got c=%b p=%b n=%b a=%b want c=%b p=%b n=%b a=%b",
                   ph, cyc, bif.conditioned, bif.positiveedge, bif.negativeedge, bif.anyedge,
                   exp_cond, exp_pos, exp_neg, |{exp_pos, exp_neg});
        end
      end
    end
    bif.waittime = 3'd3;
  endtask

  task automatic test_enable();
    // Fall on ch0; disable at count 2 for 3 edges, re-enable restarts count.
    for (int ph = 0; ph < 3; ph++) begin
      case (ph)
        0: begin bif.noisysignal[0] = 1'b0; expect_at(10, 4'b0000, 4'b0001); end
        1: bif.enable[0] = 1'b0;
        default: bif.enable[0] = 1'b1;
      endcase
      repeat ((ph == 0) ? 4 : (ph == 1) ? 3 : 6) begin
        tick();
        checks++;
        if ({bif.conditioned, bif.positiveedge, bif.negativeedge, bif.anyedge} !==
            {exp_cond, exp_pos, exp_neg, |{exp_pos, exp_neg}}) begin
          errors++;
          $display("FAIL enable ph=%0d cyc=%0d got c=%b p=%b n=%b a=%b want c=%b p=%b n=%b a=%b",
                   ph, cyc, bif.conditioned, bif.positiveedge, bif.negativeedge, bif.anyedge,
                   exp_cond, exp_pos, exp_neg, |{exp_pos, exp_neg});
        end
      end
    end
  endtask

  task automatic test_reset_midcount();
    // All channels mismatched, reset at count 2, then ch3 still differs.
    for (int ph = 0; ph < 3; ph++) begin
      case (ph)
        0: bif.noisysignal = ~exp_cond;
        1: reset = 1'b1;
        default: begin reset = 1'b0; expect_at(5, ~RV & bif.noisysignal, RV & ~bif.noisysignal); end
      endcase
      repeat ((ph == 0) ? 4 : (ph == 1) ? 1 : 8) begin
        tick();
        checks++;
        if ({bif.conditioned, bif.positiveedge, bif.negativeedge, bif.anyedge} !==
            {exp_cond, exp_pos, exp_neg, |{exp_pos, exp_neg}}) begin
          errors++;
          $display("FAIL reset_mid ph=%0d cyc=%0d got c=%b p=%b n=%b a=%b want c=%b p=%b n=%b a=%b",
                   ph, cyc, bif.conditioned, bif.positiveedge, bif.negativeedge, bif.anyedge,
                   exp_cond, exp_pos, exp_neg, |{exp_pos, exp_neg});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_waittime();
    test_enable();
    test_reset_midcount();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_multiinputconditioner
